// File: rtl/sr_latch_ctrl.sv
// ---------------------------------------------------------------------------
// sr_latch_ctrl
//   Shares a bank of NLAT enable-gated SR latches between NREQ requesters.
//   A round-robin arbiter grants one SET/RESET request at a time and an FSM
//   sequences the target latch pins: SETUP (s/r driven), PULSE (en high for
//   PULSE_W cycles), HOLD (en low, s/r held), then acks the requester.
//   s and r are never both driven high on any latch.
//
// Ports
//   clk       in   1         system clock, rising edge
//   rst       in   1         asynchronous reset, active-low
//   req       in   NREQ      level request per requester, held until ack
//   cmd       in   NREQ      per requester: 1 = SET, 0 = RESET
//   idx       in   NREQ*IW   per requester latch index, requester k at [k*IW +: IW]
//   ack       out  NREQ      one-cycle completion pulse to the granted requester
//   err       out  1         pulses with ack when the captured index is >= NLAT
//   latch_s   out  NLAT      s pin per latch
//   latch_r   out  NLAT      r pin per latch
//   latch_en  out  NLAT      en pin per latch
//   busy      out  1         high whenever the FSM is not idle
//   mirror    out  NLAT      controller copy of each latch q
// ---------------------------------------------------------------------------
module sr_latch_ctrl #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned NLAT    = 8,
    parameter int unsigned IW      = 3,
    parameter int unsigned PULSE_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      cmd,
    input  logic [NREQ*IW-1:0]   idx,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [NLAT-1:0]      latch_s,
    output logic [NLAT-1:0]      latch_r,
    output logic [NLAT-1:0]      latch_en,
    output logic                 busy,
    output logic [NLAT-1:0]      mirror
);

    localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // FSM state
    state_t            r_state;
    state_t            w_state_nxt;

    // Arbiter and captured operation
    logic [RW-1:0]     r_ptr;
    logic [RW-1:0]     r_gnt;
    logic              r_cmd;
    logic [IW-1:0]     r_idx;
    logic              r_bad;
    logic [CW-1:0]     r_cnt;

    // Registered outputs
    logic [NREQ-1:0]   r_ack;
    logic              r_err;
    logic [NLAT-1:0]   r_latch_s;
    logic [NLAT-1:0]   r_latch_r;
    logic [NLAT-1:0]   r_latch_en;
    logic              r_busy;
    logic [NLAT-1:0]   r_mirror;

    // Combinational helpers
    logic [IW-1:0]     w_idx_arr [NREQ];
    logic [NREQ-1:0]   w_req_eff;
    logic              w_any;
    logic [RW-1:0]     w_gnt;
    logic              w_sel_cmd;
    logic [IW-1:0]     w_sel_idx;
    logic              w_op_cmd;
    logic [IW-1:0]     w_op_idx;
    logic [NLAT-1:0]   w_hit;
    logic [NREQ-1:0]   w_ack_nxt;
    logic              w_err_nxt;
    logic [NLAT-1:0]   w_s_nxt;
    logic [NLAT-1:0]   w_r_nxt;
    logic [NLAT-1:0]   w_en_nxt;
    logic              w_busy_nxt;

    // Unpack per-requester latch indices
    for (genvar g = 0; g < NREQ; g++) begin : g_idx
        assign w_idx_arr[g] = idx[g*IW +: IW];
    end

    // Round-robin pick: first request at or after r_ptr. The requester being
    // acked this cycle is masked so a held or re-raised req is not re-granted.
    always_comb begin
        w_req_eff = req & ~r_ack;
        w_any     = 1'b0;
        w_gnt     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_any && w_req_eff[RW'((32'(r_ptr) + i) % NREQ)]) begin
                w_any = 1'b1;
                w_gnt = RW'((32'(r_ptr) + i) % NREQ);
            end
        end
    end

    assign w_sel_cmd = cmd[w_gnt];
    assign w_sel_idx = w_idx_arr[w_gnt];

    // Operation seen by the output logic: the fresh pick on the grant edge,
    // the captured one afterwards.
    assign w_op_cmd = (r_state == ST_IDLE) ? w_sel_cmd : r_cmd;
    assign w_op_idx = (r_state == ST_IDLE) ? w_sel_idx : r_idx;

    // One-hot target; all-zero for an out-of-range index
    always_comb begin
        w_hit = '0;
        for (int unsigned b = 0; b < NLAT; b++) begin
            w_hit[b] = (32'(w_op_idx) == b);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = ST_SETUP;
            ST_SETUP: w_state_nxt = ST_PULSE;
            ST_PULSE: if (r_cnt == '0) w_state_nxt = ST_HOLD;
            ST_HOLD:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs, keyed on the
    // state being entered so pins line up with the state they belong to.
    always_comb begin
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_s_nxt    = '0;
        w_r_nxt    = '0;
        w_en_nxt   = '0;
        w_ack_nxt  = '0;
        w_err_nxt  = 1'b0;
        if (w_busy_nxt) begin
            w_s_nxt = w_op_cmd ? w_hit : '0;
            w_r_nxt = w_op_cmd ? '0 : w_hit;
            if (w_state_nxt == ST_PULSE) begin
                w_en_nxt = w_hit;
            end
        end
        if (r_state == ST_HOLD) begin
            w_ack_nxt[r_gnt] = 1'b1;
            w_err_nxt        = r_bad;
        end
    end

    // Grant capture, rr pointer and pulse-width counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_gnt <= '0;
            r_cmd <= 1'b0;
            r_idx <= '0;
            r_bad <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_gnt <= w_gnt;
                r_cmd <= w_sel_cmd;
                r_idx <= w_sel_idx;
                r_bad <= (32'(w_sel_idx) >= NLAT);
                r_ptr <= RW'((32'(w_gnt) + 32'd1) % NREQ);
            end
            if (r_state == ST_SETUP) begin
                r_cnt <= CW'(PULSE_W - 1);
            end else if (r_state == ST_PULSE && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_latch_s  <= '0;
            r_latch_r  <= '0;
            r_latch_en <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_latch_s  <= w_s_nxt;
            r_latch_r  <= w_r_nxt;
            r_latch_en <= w_en_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Mirror commits on HOLD exit, becoming visible together with ack.
    // In HOLD w_hit decodes the captured index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mirror <= '0;
        end else if (r_state == ST_HOLD && !r_bad) begin
            r_mirror <= (r_mirror & ~w_hit) | (r_cmd ? w_hit : '0);
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign latch_s  = r_latch_s;
    assign latch_r  = r_latch_r;
    assign latch_en = r_latch_en;
    assign busy     = r_busy;
    assign mirror   = r_mirror;

`ifndef SYNTHESIS
    // Pin-level safety properties
    a_no_sr_overlap: assert property (@(posedge clk) disable iff (!rst)
        (latch_s & latch_r) == '0);
    a_single_target: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(latch_s | latch_r));
    a_en_with_data: assert property (@(posedge clk) disable iff (!rst)
        (latch_en & ~(latch_s | latch_r)) == '0);
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(ack));
    a_err_with_ack: assert property (@(posedge clk) disable iff (!rst)
        err |-> (ack != '0));
`endif

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sr_latch_ctrl
//   Scoreboard bench for sr_latch_ctrl. Each issued round of requests is
//   turned into an ordered list of expected completions by a transaction-level
//   round-robin model; a monitor pops one entry per observed ack and also
//   checks every cycle's latch pins against the schedule of the active entry.
// ---------------------------------------------------------------------------
module tb_sr_latch_ctrl;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned NLAT    = 6;
    localparam int unsigned IW      = 3;
    localparam int unsigned PULSE_W = 2;
    localparam int unsigned RW      = 2;
    localparam int unsigned LW      = 3;
    localparam int          LAT     = PULSE_W + 3;

    typedef logic [IW-1:0] idx_arr_t [NREQ];

    typedef struct {
        int              id;
        bit              cmd;
        int              idx;
        bit              err;
        logic [NLAT-1:0] mir;
        int              start;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      cmd;
    logic [NREQ*IW-1:0]   idx;
    logic [IW-1:0]        idx_a [NREQ];
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic [NLAT-1:0]      latch_s;
    logic [NLAT-1:0]      latch_r;
    logic [NLAT-1:0]      latch_en;
    logic                 busy;
    logic [NLAT-1:0]      mirror;

    exp_t            sb[$];
    int              n_chk      = 0;
    int              n_pass     = 0;
    int              cyc        = 0;
    int              m_ptr      = 0;
    logic [NLAT-1:0] m_mirror   = '0;
    logic [NLAT-1:0] mon_mirror = '0;

    for (genvar g = 0; g < NREQ; g++) begin : g_idx
        assign idx[g*IW +: IW] = idx_a[g];
    end

    sr_latch_ctrl #(
        .NREQ    (NREQ),
        .NLAT    (NLAT),
        .IW      (IW),
        .PULSE_W (PULSE_W)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .req      (req),
        .cmd      (cmd),
        .idx      (idx),
        .ack      (ack),
        .err      (err),
        .latch_s  (latch_s),
        .latch_r  (latch_r),
        .latch_en (latch_en),
        .busy     (busy),
        .mirror   (mirror)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // Monitor: pop on ack, otherwise check pins against the head entry
    task automatic monitor_step();
        exp_t            h;
        int              k;
        logic [NLAT-1:0] e_s;
        logic [NLAT-1:0] e_r;
        logic [NLAT-1:0] e_en;
        logic            e_busy;
        e_s = '0; e_r = '0; e_en = '0; e_busy = 1'b0;
        if (ack != '0 || err) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'({err, ack}), 32'(0));
            end else begin
                h = sb.pop_front();
                check("ack_vec", 32'(ack), 32'(1) << h.id);
                check("err", 32'(err), 32'(h.err));
                check("ack_latency", 32'(cyc - h.start), 32'(LAT));
                check("mirror_at_ack", 32'(mirror), 32'(h.mir));
                mon_mirror = h.mir;
            end
        end else if (sb.size() > 0 && (cyc - sb[0].start) > LAT) begin
            h = sb.pop_front();
            check("ack_timeout", 32'(ack), 32'(1) << h.id);
            mon_mirror = h.mir;
        end
        if (sb.size() > 0) begin
            k = cyc - sb[0].start;
            if (k >= 1 && k <= PULSE_W + 2) begin
                e_busy = 1'b1;
                if (!sb[0].err) begin
                    if (sb[0].cmd) e_s[LW'(sb[0].idx)] = 1'b1;
                    else           e_r[LW'(sb[0].idx)] = 1'b1;
                    if (k >= 2 && k <= PULSE_W + 1) e_en[LW'(sb[0].idx)] = 1'b1;
                end
            end
        end
        check("latch_s", 32'(latch_s), 32'(e_s));
        check("latch_r", 32'(latch_r), 32'(e_r));
        check("latch_en", 32'(latch_en), 32'(e_en));
        check("busy", 32'(busy), 32'(e_busy));
        check("mirror", 32'(mirror), 32'(mon_mirror));
        check("s_and_r", 32'(latch_s & latch_r), 32'(0));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) monitor_step();
        end
    end

    // Requesters drop req when they see their ack
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ack != '0) req = req & ~ack;
        end
    end

    // Model a round: requests in `set` served in rr order from m_ptr,
    // each taking LAT cycles back-to-back from the assertion point.
    task automatic issue_round(input logic [NREQ-1:0] set, input logic [NREQ-1:0] cv,
                               input idx_arr_t iv, output int first);
        exp_t e;
        int   n;
        int   k;
        int   last;
        int   s0;
        cmd = cv;
        for (int i = 0; i < NREQ; i++) idx_a[i] = iv[i];
        s0 = cyc; n = 0; first = 0; last = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = (m_ptr + i) % NREQ;
            if (set[RW'(k)]) begin
                e.id    = k;
                e.cmd   = cv[RW'(k)];
                e.idx   = int'(iv[k]);
                e.err   = (e.idx >= NLAT);
                if (!e.err) m_mirror[LW'(e.idx)] = e.cmd;
                e.mir   = m_mirror;
                e.start = s0 + n * LAT;
                sb.push_back(e);
                if (n == 0) first = k;
                last = k;
                n++;
            end
        end
        m_ptr = (last + 1) % NREQ;
        req = set;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    // Optionally drop the first grantee's req and scramble its cmd/idx right
    // after its grant; the captured operation must still complete.
    task automatic run_round(input logic [NREQ-1:0] set, input logic [NREQ-1:0] cv,
                             input idx_arr_t iv, input bit early_drop);
        int first;
        issue_round(set, cv, iv, first);
        if (early_drop) begin
            @(negedge clk);
            req[RW'(first)]   = 1'b0;
            cmd[RW'(first)]   = ~cmd[RW'(first)];
            idx_a[first]      = IW'($urandom);
        end
        drain();
    endtask

    task automatic reset_mid_pulse();
        idx_arr_t iv;
        int       first;
        for (int i = 0; i < NREQ; i++) iv[i] = IW'(2);
        issue_round(NREQ'(4'b0100), NREQ'(4'b1111), iv, first);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_latch_en", 32'(latch_en), 32'(0));
        check("rst_latch_s", 32'(latch_s | latch_r), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_mirror", 32'(mirror), 32'(0));
        check("rst_ack", 32'({err, ack}), 32'(0));
        sb.delete();
        req        = '0;
        m_ptr      = 0;
        m_mirror   = '0;
        mon_mirror = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        idx_arr_t        iv;
        logic [NREQ-1:0] set;
        logic [NREQ-1:0] cv;
        rst_n = 1'b0;
        req   = '0;
        cmd   = '0;
        for (int i = 0; i < NREQ; i++) idx_a[i] = '0;
        #1;
        check("reset_ack", 32'({err, ack}), 32'(0));
        check("reset_pins", 32'({latch_s, latch_r, latch_en}), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_mirror", 32'(mirror), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single SET of latch 3 by requester 0
        for (int i = 0; i < NREQ; i++) iv[i] = '0;
        iv[0] = IW'(3);
        run_round(NREQ'(4'b0001), NREQ'(4'b0001), iv, 1'b0);

        // All requesters SET latch k
        for (int i = 0; i < NREQ; i++) iv[i] = IW'(i);
        run_round(NREQ'(4'b1111), NREQ'(4'b1111), iv, 1'b0);

        // SET then RESET of latch 5 from two requesters
        for (int i = 0; i < NREQ; i++) iv[i] = IW'(5);
        run_round(NREQ'(4'b0011), NREQ'(4'b0001), iv, 1'b0);
        run_round(NREQ'(4'b0011), NREQ'(4'b0010), iv, 1'b0);

        // Out-of-range index
        for (int i = 0; i < NREQ; i++) iv[i] = IW'(7);
        run_round(NREQ'(4'b0001), NREQ'(4'b0001), iv, 1'b0);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            set = NREQ'($urandom_range(1, 15));
            cv  = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) iv[i] = IW'($urandom);
            run_round(set, cv, iv, ($urandom_range(0, 3) == 0));
        end

        reset_mid_pulse();

        for (int r = 0; r < 8; r++) begin
            set = NREQ'($urandom_range(1, 15));
            cv  = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) iv[i] = IW'($urandom);
            run_round(set, cv, iv, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
